wb_retire_stage: RTL and testbench

- Parametrised writeback/retire stage for the LoongArch pipeline. Replaces the single-entry, always-ready WB latch.
- A QDEPTH-entry in-order retire queue sits between MEM and the register file / CSR unit. It handles multi-cycle CSR reads, selects exceptions by priority from a generic EXC_NUM vector, and exports forwarding data for every queued entry to ID.

---
 rtl/wb_pkg.sv | 47 ++++
 rtl/wb_retire_fifo.sv | 146 ++++++++++++++
 rtl/wb_retire_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_wb_retire_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared constants for the writeback/retire stage: exception
//               source indices, the exception-code table and entry field
//               widths.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Field widths
    localparam int DEST_W    = 5;
    localparam int CSR_NUM_W = 14;
    localparam int ECODE_W   = 6;
    localparam int ESUB_W    = 9;

    // Exception source indices; index 0 has the highest priority
    localparam int EXC_INT  = 0;
    localparam int EXC_ADEF = 1;
    localparam int EXC_INE  = 2;
    localparam int EXC_SYS  = 3;
    localparam int EXC_BRK  = 4;
    localparam int EXC_ALE  = 5;

    // Architectural exception codes for each source
    localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h0;
    localparam logic [ECODE_W-1:0] ECODE_ADEF = 6'h8;
    localparam logic [ECODE_W-1:0] ECODE_INE  = 6'hd;
    localparam logic [ECODE_W-1:0] ECODE_SYS  = 6'hb;
    localparam logic [ECODE_W-1:0] ECODE_BRK  = 6'hc;
    localparam logic [ECODE_W-1:0] ECODE_ALE  = 6'h9;

    // Map an exception source index to its code; unknown sources report 0
    function automatic logic [ECODE_W-1:0] ecode_of(input int idx);
        case (idx)
            EXC_INT:  return ECODE_INT;
            EXC_ADEF: return ECODE_ADEF;
            EXC_INE:  return ECODE_INE;
            EXC_SYS:  return ECODE_SYS;
            EXC_BRK:  return ECODE_BRK;
            EXC_ALE:  return ECODE_ALE;
            default:  return '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_retire_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_retire_fifo
// Description : In-order retire queue storage. Holds QDEPTH entries, exposes
//               the head entry combinationally and flattens every live entry
//               into forwarding vectors ordered oldest (index 0) to youngest.
// Revision    : 1.0 - initial release
// Ports       : clk/rst        clock, asynchronous active-high reset
//               i_flush        clear all entries at the next edge
//               i_push/i_*     enqueue one entry
//               i_pop          retire the head entry
//               o_head_*       head entry fields, o_head_valid when non-empty
//               o_full         count == QDEPTH
//               o_fwd_*        per-entry forwarding vectors, 0 when not live
// ============================================================================
module wb_retire_fifo
    import wb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int QDEPTH  = 2,
    parameter int EXC_NUM = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [XLEN-1:0]          i_pc,
    input  logic [DEST_W-1:0]        i_dest,
    input  logic [XLEN-1:0]          i_result,
    input  logic                     i_gr_we,
    input  logic [EXC_NUM-1:0]       i_exc,
    input  logic                     i_ertn,
    input  logic                     i_op_csr,
    input  logic [CSR_NUM_W-1:0]     i_csr_num,
    input  logic                     i_csr_we,
    input  logic [XLEN-1:0]          i_csr_wmask,
    output logic                     o_head_valid,
    output logic                     o_full,
    output logic [XLEN-1:0]          o_head_pc,
    output logic [DEST_W-1:0]        o_head_dest,
    output logic [XLEN-1:0]          o_head_result,
    output logic                     o_head_gr_we,
    output logic [EXC_NUM-1:0]       o_head_exc,
    output logic                     o_head_ertn,
    output logic                     o_head_op_csr,
    output logic [CSR_NUM_W-1:0]     o_head_csr_num,
    output logic                     o_head_csr_we,
    output logic [XLEN-1:0]          o_head_csr_wmask,
    output logic [DEST_W*QDEPTH-1:0] o_fwd_dest,
    output logic [XLEN*QDEPTH-1:0]   o_fwd_data,
    output logic [QDEPTH-1:0]        o_fwd_csr
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;

    logic [XLEN-1:0]      r_pc       [QDEPTH];
    logic [DEST_W-1:0]    r_dest     [QDEPTH];
    logic [XLEN-1:0]      r_result   [QDEPTH];
    logic                 r_gr_we    [QDEPTH];
    logic [EXC_NUM-1:0]   r_exc      [QDEPTH];
    logic                 r_ertn     [QDEPTH];
    logic                 r_op_csr   [QDEPTH];
    logic [CSR_NUM_W-1:0] r_csr_num  [QDEPTH];
    logic                 r_csr_we   [QDEPTH];
    logic [XLEN-1:0]      r_csr_wmask[QDEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_pc[i]        <= '0;
                r_dest[i]      <= '0;
                r_result[i]    <= '0;
                r_gr_we[i]     <= 1'b0;
                r_exc[i]       <= '0;
                r_ertn[i]      <= 1'b0;
                r_op_csr[i]    <= 1'b0;
                r_csr_num[i]   <= '0;
                r_csr_we[i]    <= 1'b0;
                r_csr_wmask[i] <= '0;
            end
        end else if (i_flush) begin
            // Stale payload is left in place; it is masked by the count
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_pc[r_tail]        <= i_pc;
                r_dest[r_tail]      <= i_dest;
                r_result[r_tail]    <= i_result;
                r_gr_we[r_tail]     <= i_gr_we;
                r_exc[r_tail]       <= i_exc;
                r_ertn[r_tail]      <= i_ertn;
                r_op_csr[r_tail]    <= i_op_csr;
                r_csr_num[r_tail]   <= i_csr_num;
                r_csr_we[r_tail]    <= i_csr_we;
                r_csr_wmask[r_tail] <= i_csr_wmask;
                r_tail              <= r_tail + PTR_W'(1);
            end
            if (i_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_valid     = (r_count != '0);
    assign o_full           = (r_count == CNT_W'(QDEPTH));
    assign o_head_pc        = r_pc[r_head];
    assign o_head_dest      = r_dest[r_head];
    assign o_head_result    = r_result[r_head];
    assign o_head_gr_we     = r_gr_we[r_head];
    assign o_head_exc       = r_exc[r_head];
    assign o_head_ertn      = r_ertn[r_head];
    assign o_head_op_csr    = r_op_csr[r_head];
    assign o_head_csr_num   = r_csr_num[r_head];
    assign o_head_csr_we    = r_csr_we[r_head];
    assign o_head_csr_wmask = r_csr_wmask[r_head];

    // Forward slot k carries the k-th oldest entry, so the youngest live
    // entry sits at the highest live index.
    for (genvar k = 0; k < QDEPTH; k++) begin : g_fwd
        logic [PTR_W-1:0] w_slot;
        logic             w_live;
        assign w_slot = r_head + PTR_W'(k);
        assign w_live = (CNT_W'(k) < r_count);
        assign o_fwd_dest[k*DEST_W +: DEST_W] = w_live ? r_dest[w_slot]   : '0;
        assign o_fwd_data[k*XLEN +: XLEN]     = w_live ? r_result[w_slot] : '0;
        assign o_fwd_csr[k]                   = w_live & r_op_csr[w_slot];
    end

endmodule
`default_nettype wire

// File: rtl/wb_retire_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_retire_stage
// Description : Writeback/retire stage. A QDEPTH-entry in-order queue between
//               MEM and the register file / CSR unit; waits CSR_LAT extra
//               cycles for CSR reads, reports the highest-priority exception
//               and exports forwarding data for every queued entry.
// Revision    : 1.0 - initial release
// Options     : WB_PERF_CNT_EN - adds perf_retired / perf_csr_stall counters
// Ports       : clk, reset (async, active-high), csr_reset (sync flush)
//               in_*            MEM entry handshake and payload
//               rf_*            GPR write port
//               csr_re/num/rvalue, csr_we/wmask/wvalue, csr_plv  CSR unit
//               wb_*, ertn_flush  exception / ertn report
//               fwd_*           per-entry forwarding to ID (oldest first)
//               debug_wb_*      retire trace
// ============================================================================
module wb_retire_stage
    import wb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int QDEPTH  = 2,
    parameter int EXC_NUM = 6,
    parameter int CSR_LAT = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     csr_reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [DEST_W-1:0]        in_dest,
    input  logic [XLEN-1:0]          in_result,
    input  logic                     in_gr_we,
    input  logic [EXC_NUM-1:0]       in_exc,
    input  logic                     in_ertn,
    input  logic                     in_op_csr,
    input  logic [CSR_NUM_W-1:0]     in_csr_num,
    input  logic                     in_csr_we,
    input  logic [XLEN-1:0]          in_csr_wmask,
    output logic                     rf_we,
    output logic [DEST_W-1:0]        rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic                     csr_re,
    output logic [CSR_NUM_W-1:0]     csr_num,
    input  logic [XLEN-1:0]          csr_rvalue,
    output logic                     csr_we,
    output logic [XLEN-1:0]          csr_wmask,
    output logic [XLEN-1:0]          csr_wvalue,
    input  logic [1:0]               csr_plv,
    output logic                     wb_ex,
    output logic [ECODE_W-1:0]       wb_ecode,
    output logic [ESUB_W-1:0]        wb_esubcode,
    output logic [XLEN-1:0]          wb_pc,
    output logic [XLEN-1:0]          wb_vaddr,
    output logic                     ertn_flush,
    output logic [DEST_W*QDEPTH-1:0] fwd_dest,
    output logic [XLEN*QDEPTH-1:0]   fwd_data,
    output logic [QDEPTH-1:0]        fwd_csr,
    output logic [XLEN-1:0]          debug_wb_pc,
    output logic [3:0]               debug_wb_rf_we,
    output logic [DEST_W-1:0]        debug_wb_rf_wnum,
    output logic [XLEN-1:0]          debug_wb_rf_wdata
`ifdef WB_PERF_CNT_EN
    ,
    output logic [63:0]              perf_retired,
    output logic [31:0]              perf_csr_stall
`endif
);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_CSR_WAIT = 1'b1;
    localparam logic [1:0] C_LAT      = 2'(CSR_LAT);

    logic [0:0]           r_state;
    logic [1:0]           r_wcnt;

    logic                 w_head_valid;
    logic                 w_full;
    logic [XLEN-1:0]      w_h_pc;
    logic [DEST_W-1:0]    w_h_dest;
    logic [XLEN-1:0]      w_h_result;
    logic                 w_h_gr_we;
    logic [EXC_NUM-1:0]   w_h_exc;
    logic                 w_h_ertn;
    logic                 w_h_op_csr;
    logic [CSR_NUM_W-1:0] w_h_csr_num;
    logic                 w_h_csr_we;
    logic [XLEN-1:0]      w_h_csr_wmask;

    logic                 w_head_exc;
    logic                 w_csr_head;
    logic                 w_lat_done;
    logic                 w_retire;
    logic                 w_wb_ex;
    logic                 w_flush_cyc;
    logic                 w_push;
    logic                 w_rf_we;
    logic [DEST_W-1:0]    w_rf_waddr;
    logic [XLEN-1:0]      w_rf_wdata;
    logic [ECODE_W-1:0]   w_ecode;

    wb_retire_fifo #(
        .XLEN    (XLEN),
        .QDEPTH  (QDEPTH),
        .EXC_NUM (EXC_NUM)
    ) u_fifo (
        .clk              (clk),
        .rst              (reset),
        .i_flush          (w_flush_cyc),
        .i_push           (w_push),
        .i_pop            (w_retire),
        .i_pc             (in_pc),
        .i_dest           (in_dest),
        .i_result         (in_result),
        .i_gr_we          (in_gr_we),
        .i_exc            (in_exc),
        .i_ertn           (in_ertn),
        .i_op_csr         (in_op_csr),
        .i_csr_num        (in_csr_num),
        .i_csr_we         (in_csr_we),
        .i_csr_wmask      (in_csr_wmask),
        .o_head_valid     (w_head_valid),
        .o_full           (w_full),
        .o_head_pc        (w_h_pc),
        .o_head_dest      (w_h_dest),
        .o_head_result    (w_h_result),
        .o_head_gr_we     (w_h_gr_we),
        .o_head_exc       (w_h_exc),
        .o_head_ertn      (w_h_ertn),
        .o_head_op_csr    (w_h_op_csr),
        .o_head_csr_num   (w_h_csr_num),
        .o_head_csr_we    (w_h_csr_we),
        .o_head_csr_wmask (w_h_csr_wmask),
        .o_fwd_dest       (fwd_dest),
        .o_fwd_data       (fwd_data),
        .o_fwd_csr        (fwd_csr)
    );

    // A faulting head never issues its CSR read; it reports immediately.
    assign w_head_exc = (|w_h_exc) | w_h_ertn;
    assign w_csr_head = w_head_valid & w_h_op_csr & ~w_head_exc;
    assign w_lat_done = (CSR_LAT == 0) || ((r_state == S_CSR_WAIT) && (r_wcnt == C_LAT));

    // Entries being flushed by csr_reset do not commit anything.
    assign w_retire    = w_head_valid & ~csr_reset & (~w_csr_head | w_lat_done);
    assign w_wb_ex     = w_retire & w_head_exc;
    assign w_flush_cyc = w_wb_ex | csr_reset;
    assign in_ready    = ~w_full & ~w_flush_cyc;
    assign w_push      = in_valid & in_ready;

    // Sequencer: counts CSR read latency for the head entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wcnt  <= 2'd0;
        end else if (w_retire || csr_reset) begin
            r_state <= S_IDLE;
            r_wcnt  <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_csr_head) begin
                        r_state <= S_CSR_WAIT;
                        r_wcnt  <= 2'd1;
                    end
                end
                S_CSR_WAIT: r_wcnt <= r_wcnt + 2'd1;
                default: begin
                    r_state <= S_IDLE;
                    r_wcnt  <= 2'd0;
                end
            endcase
        end
    end

    // Lowest set index wins: scan from the top so lower indices overwrite
    always_comb begin
        w_ecode = '0;
        for (int i = EXC_NUM - 1; i >= 0; i--) begin
            if (w_h_exc[i]) begin
                w_ecode = ecode_of(i);
            end
        end
    end

    assign w_rf_we    = w_retire & w_h_gr_we & ~w_head_exc;
    assign w_rf_waddr = w_retire ? w_h_dest : '0;
    assign w_rf_wdata = w_retire ? (w_h_op_csr ? csr_rvalue : w_h_result) : '0;

    assign rf_we      = w_rf_we;
    assign rf_waddr   = w_rf_waddr;
    assign rf_wdata   = w_rf_wdata;

    assign csr_re     = w_csr_head;
    assign csr_num    = w_csr_head ? w_h_csr_num : '0;
    assign csr_we     = w_retire & w_h_csr_we & ~w_head_exc;
    assign csr_wmask  = w_retire ? w_h_csr_wmask : '0;
    assign csr_wvalue = w_retire ? w_h_result : '0;

    assign wb_ex       = w_wb_ex;
    assign wb_ecode    = w_wb_ex ? w_ecode : '0;
    assign wb_esubcode = '0;
    assign wb_pc       = w_wb_ex ? w_h_pc : '0;
    assign wb_vaddr    = w_wb_ex ? w_h_result : '0;
    assign ertn_flush  = w_retire & w_h_ertn & (csr_plv == 2'd0);

    assign debug_wb_pc       = w_retire ? w_h_pc : '0;
    assign debug_wb_rf_we    = {4{w_rf_we}};
    assign debug_wb_rf_wnum  = w_rf_waddr;
    assign debug_wb_rf_wdata = w_rf_wdata;

`ifdef WB_PERF_CNT_EN
    logic [63:0] r_perf_retired;
    logic [31:0] r_perf_csr_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_retired   <= '0;
            r_perf_csr_stall <= '0;
        end else begin
            if (w_retire && !w_head_exc) begin
                r_perf_retired <= r_perf_retired + 64'd1;
            end
            if ((r_state == S_CSR_WAIT) && !w_retire) begin
                r_perf_csr_stall <= r_perf_csr_stall + 32'd1;
            end
        end
    end

    assign perf_retired   = r_perf_retired;
    assign perf_csr_stall = r_perf_csr_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_retire_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_retire_stage
// Description : Self-checking bench for wb_retire_stage (QDEPTH=2, CSR_LAT=2).
//               A queue-based reference model predicts every output each
//               cycle; directed steps cover the key scenarios, followed by
//               randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_retire_stage;

    localparam int XLEN = 32;
    localparam int QD   = 2;
    localparam int EN   = 6;
    localparam int LAT  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, csr_reset, in_valid, in_ready;
    logic [XLEN-1:0]   in_pc, in_result, in_csr_wmask;
    logic [4:0]        in_dest;
    logic              in_gr_we, in_ertn, in_op_csr, in_csr_we;
    logic [EN-1:0]     in_exc;
    logic [13:0]       in_csr_num;
    logic              rf_we, csr_re, csr_we, wb_ex, ertn_flush;
    logic [4:0]        rf_waddr, debug_wb_rf_wnum;
    logic [XLEN-1:0]   rf_wdata, csr_rvalue, csr_wmask, csr_wvalue, wb_pc, wb_vaddr;
    logic [13:0]       csr_num;
    logic [1:0]        csr_plv;
    logic [5:0]        wb_ecode;
    logic [8:0]        wb_esubcode;
    logic [5*QD-1:0]   fwd_dest;
    logic [XLEN*QD-1:0] fwd_data;
    logic [QD-1:0]     fwd_csr;
    logic [XLEN-1:0]   debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]        debug_wb_rf_we;

    wb_retire_stage #(.XLEN(XLEN), .QDEPTH(QD), .EXC_NUM(EN), .CSR_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .csr_reset(csr_reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_dest(in_dest),
        .in_result(in_result), .in_gr_we(in_gr_we), .in_exc(in_exc), .in_ertn(in_ertn),
        .in_op_csr(in_op_csr), .in_csr_num(in_csr_num), .in_csr_we(in_csr_we),
        .in_csr_wmask(in_csr_wmask),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_plv(csr_plv),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
        .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_csr(fwd_csr),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] result;
        logic        gr_we;
        logic [5:0]  exc;
        logic        ertn;
        logic        op_csr;
        logic [13:0] csr_num;
        logic        csr_we;
        logic [31:0] wmask;
    } ent_t;

    ent_t q[$];
    int   head_age;          // cycles the current head has already spent at the head
    int   n_cmp = 0;
    int   n_err = 0;

    logic        m_ready, m_retire, m_flush;
    logic [63:0] e [string];

    function automatic logic [5:0] code_for(input logic [5:0] exc);
        logic [5:0] tbl [6];
        tbl = '{6'h0, 6'h8, 6'hd, 6'hb, 6'hc, 6'h9};
        for (int i = 0; i < 6; i++) if (exc[i]) return tbl[i];
        return 6'h0;
    endfunction

    task automatic model_eval();
        ent_t h;
        logic hv, hexc, csr_head, wbex, rfwe;
        logic [63:0] fd, fdat, fc;
        hv = (q.size() > 0);
        if (hv) h = q[0];
        else h = '{default: '0};
        hexc     = hv && ((|h.exc) || h.ertn);
        csr_head = hv && h.op_csr && !hexc;
        m_retire = hv && !csr_reset && (!csr_head || head_age == LAT);
        wbex     = m_retire && hexc;
        m_flush  = wbex || csr_reset;
        m_ready  = (q.size() < QD) && !m_flush;
        rfwe     = m_retire && h.gr_we && !hexc;
        e["in_ready"]   = 64'(m_ready);
        e["rf_we"]      = 64'(rfwe);
        e["rf_waddr"]   = m_retire ? 64'(h.dest) : 64'd0;
        e["rf_wdata"]   = m_retire ? (h.op_csr ? 64'(csr_rvalue) : 64'(h.result)) : 64'd0;
        e["csr_re"]     = 64'(csr_head);
        e["csr_num"]    = csr_head ? 64'(h.csr_num) : 64'd0;
        e["csr_we"]     = 64'(m_retire && h.csr_we && !hexc);
        e["csr_wmask"]  = m_retire ? 64'(h.wmask) : 64'd0;
        e["csr_wvalue"] = m_retire ? 64'(h.result) : 64'd0;
        e["wb_ex"]      = 64'(wbex);
        e["wb_ecode"]   = wbex ? 64'(code_for(h.exc)) : 64'd0;
        e["wb_pc"]      = wbex ? 64'(h.pc) : 64'd0;
        e["wb_vaddr"]   = wbex ? 64'(h.result) : 64'd0;
        e["ertn_flush"] = 64'(m_retire && h.ertn && csr_plv == 2'd0);
        e["dbg_pc"]     = m_retire ? 64'(h.pc) : 64'd0;
        e["dbg_we"]     = rfwe ? 64'hf : 64'h0;
        fd = '0; fdat = '0; fc = '0;
        for (int k = 0; k < QD; k++) begin
            if (k < q.size()) begin
                fd[5*k +: 5]    = q[k].dest;
                fdat[32*k +: 32] = q[k].result;
                fc[k]           = q[k].op_csr;
            end
        end
        e["fwd_dest"] = fd;
        e["fwd_data"] = fdat;
        e["fwd_csr"]  = fc;
    endtask

    task automatic model_update();
        ent_t n;
        if (m_flush) begin
            q.delete();
            head_age = 0;
        end else begin
            if (m_retire) begin
                void'(q.pop_front());
                head_age = 0;
            end else if (q.size() > 0) begin
                head_age++;
            end
            if (in_valid && m_ready) begin
                n = '{in_pc, in_dest, in_result, in_gr_we, in_exc, in_ertn,
                      in_op_csr, in_csr_num, in_csr_we, in_csr_wmask};
                q.push_back(n);
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        model_eval();
        chk("in_ready",   64'(in_ready),   e["in_ready"]);
        chk("rf_we",      64'(rf_we),      e["rf_we"]);
        chk("rf_waddr",   64'(rf_waddr),   e["rf_waddr"]);
        chk("rf_wdata",   64'(rf_wdata),   e["rf_wdata"]);
        chk("csr_re",     64'(csr_re),     e["csr_re"]);
        chk("csr_num",    64'(csr_num),    e["csr_num"]);
        chk("csr_we",     64'(csr_we),     e["csr_we"]);
        chk("csr_wmask",  64'(csr_wmask),  e["csr_wmask"]);
        chk("csr_wvalue", 64'(csr_wvalue), e["csr_wvalue"]);
        chk("wb_ex",      64'(wb_ex),      e["wb_ex"]);
        chk("wb_ecode",   64'(wb_ecode),   e["wb_ecode"]);
        chk("wb_esub",    64'(wb_esubcode), 64'd0);
        chk("wb_pc",      64'(wb_pc),      e["wb_pc"]);
        chk("wb_vaddr",   64'(wb_vaddr),   e["wb_vaddr"]);
        chk("ertn_flush", 64'(ertn_flush), e["ertn_flush"]);
        chk("fwd_dest",   64'(fwd_dest),   e["fwd_dest"]);
        chk("fwd_data",   64'(fwd_data),   e["fwd_data"]);
        chk("fwd_csr",    64'(fwd_csr),    e["fwd_csr"]);
        chk("dbg_pc",     64'(debug_wb_pc), e["dbg_pc"]);
        chk("dbg_we",     64'(debug_wb_rf_we), e["dbg_we"]);
        chk("dbg_wnum",   64'(debug_wb_rf_wnum), e["rf_waddr"]);
        chk("dbg_wdata",  64'(debug_wb_rf_wdata), e["rf_wdata"]);
    endtask

    // Sample on the falling edge, update the model on the rising edge
    task automatic settle();
        @(negedge clk);
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_in();
        in_valid = 0; in_pc = '0; in_dest = '0; in_result = '0; in_gr_we = 0;
        in_exc = '0; in_ertn = 0; in_op_csr = 0; in_csr_num = '0; in_csr_we = 0;
        in_csr_wmask = '0; csr_reset = 0;
    endtask

    task automatic push_csr(input logic [4:0] d);
        clear_in();
        in_valid = 1; in_dest = d; in_gr_we = 1; in_op_csr = 1; in_csr_num = 14'h5;
        in_pc = 32'h1c000040; in_result = 32'h0;
    endtask

    task automatic push_add(input logic [4:0] d, input logic [31:0] r);
        clear_in();
        in_valid = 1; in_dest = d; in_result = r; in_gr_we = 1; in_pc = 32'h1c000000 + 32'(d);
    endtask

    initial begin
        head_age = 0;
        clear_in();
        csr_rvalue = 32'hdead0000;
        csr_plv = 2'd0;
        reset = 1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        settle();
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        reset = 0;

        // Single add
        push_add(5'd5, 32'h1234);
        settle(); tick();
        clear_in();
        settle();
        chk("add_rf_we", 64'(rf_we), 64'd1);
        chk("add_rf_waddr", 64'(rf_waddr), 64'd5);
        chk("add_rf_wdata", 64'(rf_wdata), 64'h1234);
        chk("add_dbg_we", 64'(debug_wb_rf_we), 64'hf);
        tick();

        // CSR read followed by two adds: queue fills, order preserved
        push_csr(5'd7);
        settle(); chk("q_ready0", 64'(in_ready), 64'd1); tick();
        push_add(5'd2, 32'h22);
        settle(); chk("csr_re1", 64'(csr_re), 64'd1); chk("fwd_csr1", 64'(fwd_csr[0]), 64'd1);
        chk("csr_num1", 64'(csr_num), 64'h5); tick();
        push_add(5'd3, 32'h33);
        settle(); chk("q_full", 64'(in_ready), 64'd0); chk("csr_re2", 64'(csr_re), 64'd1);
        chk("fwd_csr2", 64'(fwd_csr[0]), 64'd1); tick();
        settle(); chk("csr_re3", 64'(csr_re), 64'd1); chk("csr_rf_we", 64'(rf_we), 64'd1);
        chk("csr_wdata", 64'(rf_wdata), 64'hdead0000); chk("csr_waddr", 64'(rf_waddr), 64'd7);
        chk("q_full2", 64'(in_ready), 64'd0); tick();
        settle(); chk("ord_b", 64'(rf_waddr), 64'd2); chk("fwd_csr_clr", 64'(fwd_csr), 64'd0);
        chk("q_ready4", 64'(in_ready), 64'd1); tick();
        clear_in();
        settle(); chk("ord_c", 64'(rf_waddr), 64'd3); tick();

        // Exception with a younger entry offered behind it
        clear_in();
        in_valid = 1; in_exc = 6'b011000; in_pc = 32'h1c000100; in_gr_we = 1; in_result = 32'hbad0;
        settle(); tick();
        push_add(5'd9, 32'h99);
        settle();
        chk("exc_wb_ex", 64'(wb_ex), 64'd1);
        chk("exc_ecode", 64'(wb_ecode), 64'hb);
        chk("exc_pc", 64'(wb_pc), 64'h1c000100);
        chk("exc_rf_we", 64'(rf_we), 64'd0);
        chk("exc_ready", 64'(in_ready), 64'd0);
        tick();
        clear_in();
        settle(); chk("exc_pulse", 64'(wb_ex), 64'd0); chk("exc_drop", 64'(fwd_dest), 64'd0); tick();

        // ertn at plv 0 then plv 3
        for (int p = 0; p < 2; p++) begin
            clear_in();
            in_valid = 1; in_ertn = 1; in_pc = 32'h1c000200;
            settle(); tick();
            clear_in();
            csr_plv = (p == 0) ? 2'd0 : 2'd3;
            settle();
            chk("ertn_wb_ex", 64'(wb_ex), 64'd1);
            chk("ertn_flush", 64'(ertn_flush), (p == 0) ? 64'd1 : 64'd0);
            chk("ertn_ecode", 64'(wb_ecode), 64'd0);
            tick();
        end
        csr_plv = 2'd0;

        // csr_reset with the queue full
        push_csr(5'd4); settle(); tick();
        push_add(5'd6, 32'h66); settle(); tick();
        clear_in(); csr_reset = 1;
        settle(); chk("cr_rf_we", 64'(rf_we), 64'd0); chk("cr_ready", 64'(in_ready), 64'd0); tick();
        csr_reset = 0;
        settle(); chk("cr_empty", 64'(fwd_dest), 64'd0); chk("cr_ready2", 64'(in_ready), 64'd1);
        chk("cr_csr_re", 64'(csr_re), 64'd0); tick();

        // Asynchronous reset in the middle of a CSR wait
        push_csr(5'd8); settle(); tick();
        clear_in(); settle(); tick();
        #2 reset = 1;
        #1;
        q.delete(); head_age = 0;
        check_all();
        chk("ar_rf_we", 64'(rf_we), 64'd0);
        chk("ar_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        reset = 0;
        settle(); chk("ar_csr_re", 64'(csr_re), 64'd0); tick();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            in_valid     = ($urandom_range(3) != 0);
            in_pc        = $urandom;
            in_dest      = 5'($urandom);
            in_result    = $urandom;
            in_gr_we     = 1'($urandom);
            in_exc       = ($urandom_range(7) == 0) ? 6'($urandom) : 6'd0;
            in_ertn      = ($urandom_range(15) == 0);
            in_op_csr    = ($urandom_range(3) == 0);
            in_csr_num   = 14'($urandom);
            in_csr_we    = 1'($urandom);
            in_csr_wmask = $urandom;
            csr_rvalue   = $urandom;
            csr_plv      = 2'($urandom);
            csr_reset    = ($urandom_range(24) == 0);
            settle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
